// File: rtl/line_window_ctrl_pkg.sv
// Shared types and elaboration helpers for the KxK line-window sequencer
// and the streaming blocks built around it.
package line_window_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  function automatic int col_w(input int img_w);
    return (img_w > 1) ? $clog2(img_w) : 1;
  endfunction

  function automatic int row_w(input int img_h);
    return (img_h > 1) ? $clog2(img_h) : 1;
  endfunction

  function automatic bit params_ok(input int k, input int img_w, input int img_h);
    return (k >= 1) && (k <= 8) && (k <= img_h) && (k <= img_w);
  endfunction

endpackage

// File: rtl/line_window_ctrl_if.sv
// Pixel-stream in / window-strobe out bundle between the pixel source,
// the line-window sequencer and the filter datapath.
interface line_window_ctrl_if #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
);
  localparam int COL_W = line_window_ctrl_pkg::col_w(IMG_W);
  localparam int ROW_W = line_window_ctrl_pkg::row_w(IMG_H);

  logic             pix_valid;
  logic             pix_sof;
  logic             err_clr;
  logic             lb_shift_en;
  logic             win_valid;
  logic [COL_W-1:0] win_x;
  logic [ROW_W-1:0] win_y;
  logic             frame_done;
  logic             busy;
  logic             sof_err;

  modport master (
    output pix_valid, pix_sof, err_clr,
    input  lb_shift_en, win_valid, win_x, win_y, frame_done, busy, sof_err
  );

  modport slave (
    input  pix_valid, pix_sof, err_clr,
    output lb_shift_en, win_valid, win_x, win_y, frame_done, busy, sof_err
  );
endinterface

// File: rtl/raster_pos_counter.sv
// Raster column/row tracker. col/row/eol/eof describe the pixel presented this
// cycle; load_zero makes that pixel (0,0) so counting resumes from (1,0).
module raster_pos_counter #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  localparam int COL_W = line_window_ctrl_pkg::col_w(IMG_W),
  localparam int ROW_W = line_window_ctrl_pkg::row_w(IMG_H)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             load_zero,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             eol,
  output logic             eof
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;

  assign col = load_zero ? '0 : col_q;
  assign row = load_zero ? '0 : row_q;
  assign eol = (col == COL_LAST);
  assign eof = eol && (row == ROW_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (en) begin
      if (eol) begin
        col_q <= '0;
        row_q <= eof ? '0 : row + 1'b1;
      end else begin
        col_q <= col + 1'b1;
        row_q <= row;
      end
    end else if (load_zero) begin
      col_q <= '0;
      row_q <= '0;
    end
  end

endmodule

// File: rtl/line_window_ctrl.sv
// Sequencer for a K-1 stage line-buffer cascade: gates the shared shift enable,
// hides the priming lines and strobes each complete KxK window with its origin.
module line_window_ctrl
  import line_window_ctrl_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int K     = 3
) (
  input  logic               clock,
  input  logic               reset,
  line_window_ctrl_if.slave  bus
);

  localparam int COL_W = col_w(IMG_W);
  localparam int ROW_W = row_w(IMG_H);

  if (!params_ok(K, IMG_W, IMG_H)) begin : g_param_check
    $error("line_window_ctrl: K must be 1..8 and no larger than IMG_W or IMG_H");
  end

  state_t           state, state_nx;
  logic             acc, sof_acc, win_hit, err_set, fd_nx;
  logic             eol, eof;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             win_valid_q, frame_done_q, sof_err_q;
  logic [COL_W-1:0] win_x_q;
  logic [ROW_W-1:0] win_y_q;

  // In IDLE only a start-of-frame pixel is taken; everything else is dropped.
  assign acc     = bus.pix_valid && (state != ST_IDLE || bus.pix_sof);
  assign sof_acc = acc && bus.pix_sof;

  raster_pos_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_pos (
    .clock     (clock),
    .reset     (reset),
    .en        (acc),
    .load_zero (sof_acc),
    .col       (col),
    .row       (row),
    .eol       (eol),
    .eof       (eof)
  );

  // Rows below K-1 are only ever seen while priming, so position alone decides.
  assign win_hit = acc && (int'(col) >= K - 1) && (int'(row) >= K - 1);

  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    fd_nx    = 1'b0;
    if (sof_acc) begin
      err_set  = (state != ST_IDLE);
      state_nx = (K == 1) ? ST_RUN : ST_PRIME;
    end else if (acc) begin
      case (state)
        ST_PRIME: if (eol && int'(row) == K - 2) state_nx = ST_RUN;
        ST_RUN: begin
          if (eof) begin
            state_nx = ST_IDLE;
            fd_nx    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs registered to line up with the 1-cycle line-buffer tap latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      win_valid_q  <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      state        <= state_nx;
      win_valid_q  <= win_hit;
      frame_done_q <= fd_nx;
      if (win_hit) begin
        win_x_q <= col - COL_W'(K - 1);
        win_y_q <= row - ROW_W'(K - 1);
      end
      if (err_set)          sof_err_q <= 1'b1;
      else if (bus.err_clr) sof_err_q <= 1'b0;
    end
  end

  assign bus.lb_shift_en = acc;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.win_valid   = win_valid_q;
  assign bus.win_x       = win_x_q;
  assign bus.win_y       = win_y_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.sof_err     = sof_err_q;

endmodule

// File: tb/tb_line_window_ctrl.sv
// Bench for line_window_ctrl: K=3 and K=1 instances share one stimulus stream
// and are compared every cycle against a frame-index model of the window rules.
module tb_line_window_ctrl;
  localparam int W = 8;
  localparam int H = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  line_window_ctrl_if #(.IMG_W(W), .IMG_H(H)) bus3 ();
  line_window_ctrl_if #(.IMG_W(W), .IMG_H(H)) bus1 ();

  line_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3));
  line_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  int n_chk  = 0;
  int n_fail = 0;

  int kv [2] = '{3, 1};
  bit m_active [2];
  int m_p      [2];
  bit m_err    [2];
  bit m_win    [2];
  bit m_fd     [2];
  int m_x      [2];
  int m_y      [2];
  int cnt_win  [2];
  int cnt_fd   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_p[i] = 0; m_err[i] = 0;
      m_win[i] = 0; m_fd[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
  endtask

  // Frame modelled as a linear pixel index p; position is p%W, p/W.
  task automatic model_step(input int i, input bit v, input bit sof, input bit clr);
    bit acc, set;
    int c, r;
    acc = v && (m_active[i] || sof);
    set = 0;
    m_win[i] = 0;
    m_fd[i]  = 0;
    if (acc) begin
      if (sof) begin
        set = m_active[i];
        m_p[i] = 0;
        m_active[i] = 1;
      end
      c = m_p[i] % W;
      r = m_p[i] / W;
      if (c >= kv[i] - 1 && r >= kv[i] - 1) begin
        m_win[i] = 1;
        m_x[i] = c - (kv[i] - 1);
        m_y[i] = r - (kv[i] - 1);
      end
      if (m_p[i] == W * H - 1) begin
        m_fd[i] = 1;
        m_active[i] = 0;
        m_p[i] = 0;
      end else begin
        m_p[i]++;
      end
    end
    if (set)      m_err[i] = 1;
    else if (clr) m_err[i] = 0;
  endtask

  task automatic check_regs();
    chk("k3 win_valid",  bus3.win_valid,  m_win[0]);
    chk("k3 win_x",      bus3.win_x,      m_x[0]);
    chk("k3 win_y",      bus3.win_y,      m_y[0]);
    chk("k3 frame_done", bus3.frame_done, m_fd[0]);
    chk("k3 busy",       bus3.busy,       m_active[0]);
    chk("k3 sof_err",    bus3.sof_err,    m_err[0]);
    chk("k1 win_valid",  bus1.win_valid,  m_win[1]);
    chk("k1 win_x",      bus1.win_x,      m_x[1]);
    chk("k1 win_y",      bus1.win_y,      m_y[1]);
    chk("k1 frame_done", bus1.frame_done, m_fd[1]);
    chk("k1 busy",       bus1.busy,       m_active[1]);
    chk("k1 sof_err",    bus1.sof_err,    m_err[1]);
    if (bus3.win_valid === 1'b1)  cnt_win[0]++;
    if (bus1.win_valid === 1'b1)  cnt_win[1]++;
    if (bus3.frame_done === 1'b1) cnt_fd[0]++;
    if (bus1.frame_done === 1'b1) cnt_fd[1]++;
  endtask

  task automatic drive(input bit v, input bit sof, input bit clr);
    bus3.pix_valid = v; bus3.pix_sof = sof; bus3.err_clr = clr;
    bus1.pix_valid = v; bus1.pix_sof = sof; bus1.err_clr = clr;
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic cycle(input bit v, input bit sof, input bit clr);
    drive(v, sof, clr);
    #2;
    chk("k3 lb_shift_en", bus3.lb_shift_en, v && (m_active[0] || sof));
    chk("k1 lb_shift_en", bus1.lb_shift_en, v && (m_active[1] || sof));
    model_step(0, v, sof, clr);
    model_step(1, v, sof, clr);
    @(posedge clock);
    #1;
    check_regs();
  endtask

  task automatic frame(input int n, input bit gaps);
    for (int j = 0; j < n; j++) begin
      cycle(1'b1, j == 0, 1'b0);
      if (gaps) cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      cnt_win[i] = 0;
      cnt_fd[i]  = 0;
    end
  endtask

  task automatic async_reset();
    #2;
    drive(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("k3 lb_shift_en in reset", bus3.lb_shift_en, 0);
    @(posedge clock);
    #1;
    check_regs();
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    clear_counts();
    drive(1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check_regs();
    reset = 1'b1;

    // Valid pixels without SOF are ignored from IDLE.
    for (int j = 0; j < 4; j++) cycle(1'b1, 1'b0, 1'b0);

    // Continuous frame.
    clear_counts();
    frame(W * H, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("k3 windows continuous", cnt_win[0], 24);
    chk("k1 windows continuous", cnt_win[1], 48);
    chk("k3 frame_done count",   cnt_fd[0], 1);

    // Same frame with alternating gaps.
    clear_counts();
    frame(W * H, 1'b1);
    chk("k3 windows gapped", cnt_win[0], 24);
    chk("k1 windows gapped", cnt_win[1], 48);

    // Abort at pixel 20, restart, then clear the error.
    clear_counts();
    frame(20, 1'b0);
    frame(W * H, 1'b0);
    chk("k3 frame_done after abort", cnt_fd[0], 1);
    chk("k3 windows after abort", cnt_win[0], 24 + 2);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);

    // Two back-to-back frames.
    clear_counts();
    frame(W * H, 1'b0);
    frame(W * H, 1'b0);
    chk("k3 windows two frames", cnt_win[0], 48);
    chk("k3 frame_done two frames", cnt_fd[0], 2);

    // SOF together with err_clr mid-frame: the error set wins.
    frame(10, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    for (int j = 0; j < 5; j++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);

    // SOF landing on the final pixel restarts instead of finishing.
    clear_counts();
    frame(W * H - 1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("k3 no frame_done on sof at last pixel", cnt_fd[0], 0);
    for (int j = 0; j < W * H - 1; j++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int j = 0; j < 2000; j++)
      cycle($urandom_range(0, 9) < 8, $urandom_range(0, 99) == 0, $urandom_range(0, 31) == 0);

    // Asynchronous reset in the middle of a frame.
    frame(25, 1'b0);
    async_reset();
    for (int j = 0; j < 3; j++) cycle(1'b1, 1'b0, 1'b0);
    clear_counts();
    frame(W * H, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("k3 windows after reset", cnt_win[0], 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/line_window_ctrl.md
Name: line_window_ctrl

Overview:
Sequencer for a cascade of K-1 line-buffer shift-tap stages, each SHIFT = IMG_W deep, that forms a KxK sliding window over a raster pixel stream.
- Tracks column and row position and gates the shift enable shared by all line-buffer stages.
- Suppresses output while the line buffers prime.
- Emits a window-valid strobe with window coordinates, aligned to the registered tap outputs.
- Sits between the pixel source (camera/DMA front end) and the KxK convolution/filter datapath.

Parameters:
IMG_W, 640, pixels per line; must equal SHIFT of the line-buffer stages.
IMG_H, 480, lines per frame.
K, 3, window size (1..8); the controlled cascade has K-1 line-buffer stages.

Ports:
clock  input  1  system clock, all logic rising-edge.
reset  input  1  asynchronous, active-low reset.
pix_valid  input  1  pixel present on upstream stream this cycle.
pix_sof  input  1  qualifies pix_valid: this pixel is (col 0, row 0) of a new frame.
err_clr  input  1  synchronous clear of sof_err.
lb_shift_en  output  1  drives ivalid of every line-buffer stage and the window register shift.
win_valid  output  1  tap outputs form a complete KxK window this cycle.
win_x  output  clog2(IMG_W)  window left column, = col-(K-1).
win_y  output  clog2(IMG_H)  window top row, = row-(K-1).
frame_done  output  1  single-cycle pulse after the last pixel of a frame.
busy  output  1  high in states PRIME and RUN.
sof_err  output  1  sticky: SOF arrived before the previous frame completed.

Behaviour:
- Reset (reset=0, async): state IDLE; col, row = 0; win_valid, win_x, win_y, frame_done, sof_err, busy = 0. lb_shift_en is 0 because it is gated by state and pix_sof.
- Accepted pixel: acc = pix_valid & (state!=IDLE | pix_sof).
- lb_shift_en = acc, combinational, same cycle as the pixel. Line-buffer stages have 1-cycle registered latency.
- Counters:
  - col increments on acc and wraps IMG_W-1 -> 0.
  - On that wrap, row increments.
  - An accepted pixel with pix_sof forces that pixel to (0,0); counters then continue from (1,0).
  - Widths are clog2(IMG_W) and clog2(IMG_H); no other wrap is possible.
- States:
  - IDLE: pixels without pix_sof are ignored; no shift, no error. On acc with pix_sof, go to PRIME, or to RUN if K=1.
  - PRIME: line buffers filling; win_valid stays 0. Go to RUN on the accepted pixel at col IMG_W-1, row K-2.
  - RUN: on an accepted pixel with col>=K-1 and row>=K-1, the next cycle has win_valid=1, win_x=col-(K-1), win_y=row-(K-1). Otherwise win_valid=0 next cycle, and win_x/win_y hold their last values.
  - Frame end: the accepted pixel at (IMG_W-1, IMG_H-1) gives frame_done=1 the next cycle for exactly 1 cycle, and the state goes to IDLE.
- Gaps: pix_valid=0 freezes counters and state; win_valid=0 on the following cycle.
- SOF while in PRIME or RUN:
  - sof_err is set.
  - The pixel becomes (0,0) and the state goes to PRIME (RUN if K=1).
  - No frame_done is issued for the aborted frame.
- pix_sof on the final pixel of a frame: the restart takes priority; no frame_done; sof_err is set.
- err_clr clears sof_err. If err_clr and a new error occur in the same cycle, the set wins.
- Stale line-buffer contents from an aborted frame are never exposed, because PRIME re-fills K-1 full lines.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, PRIME=2'd1, RUN=2'd2);
  - COL_W/ROW_W width functions;
  - parameter legality check (K>=1, K<=IMG_H, K<=IMG_W).
- Sub-module raster_pos_counter: col/row counters with enable, sync load-to-zero, and end-of-line / end-of-frame flags. It is reused by other streaming blocks.

Test Plan:
All tests use IMG_W=8, IMG_H=6, K=3.
1. Reset: drive reset=0 mid-stream -> all outputs 0 immediately (async). After release with pix_valid=1 and no SOF -> lb_shift_en stays 0.
2. Continuous frame of 48 pixels starting with SOF:
   - first win_valid is 1 cycle after pixel 18 (col 2, row 2), with win_x=0, win_y=0;
   - exactly 24 win_valid cycles in total;
   - last window has win_x=5, win_y=3;
   - frame_done pulses 1 cycle after pixel 47; busy then drops.
3. Same frame with pix_valid toggling 1-0 -> identical window sequence and count; every win_valid immediately follows an accepted pixel.
4. SOF at pixel 20 -> sof_err=1; PRIME restarts; first new window follows the 19th pixel after the restart; frame_done follows 48 pixels after the restart. err_clr then returns sof_err to 0.
5. Two back-to-back frames with no gap -> frame_done pulses at cycles 48 and 96; 48 windows in total; sof_err stays 0.
6. K=1 variant, one frame -> win_valid after every accepted pixel; win_x/win_y equal col/row; 48 windows.
